// File: rtl/serial_paralelo_bc_pkg.sv
// Shared definitions for the serial-to-parallel comma-alignment receiver:
// the comma character and the alignment state encoding.
package serial_paralelo_bc_pkg;

    // Alignment / idle character
    localparam logic [7:0] COMMA = 8'hBC;

    // Alignment state machine encoding
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } serpar_state_e;

endpackage

// File: rtl/serial_paralelo_bc_if.sv
// Bus between the serial source and the receiver: serial bit in, aligned
// word plus status out. The source side is the master, the receiver the slave.
interface serial_paralelo_bc_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       word_tick;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  word_tick
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output word_tick
    );

endinterface

// File: rtl/serial_paralelo_bc_bc_detector.sv
// Comma alignment tracker: finds the first comma, then requires BC_COUNT
// consecutive commas on the resulting 8-bit grid before declaring the link
// active. Once active it keeps the word grid and flags each word boundary.
module bc_detector
    import serial_paralelo_bc_pkg::*;
#(
    parameter int unsigned BC_COUNT = 4,
    parameter logic [7:0]  COMMA_CH = COMMA
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] cand,
    output logic       boundary,
    output logic       active
);

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    serpar_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    bc_cnt_q, bc_cnt_d;
    logic          active_q, active_d;

    logic is_comma;
    logic at_boundary;

    assign is_comma    = (cand == COMMA_CH);
    assign at_boundary = (bit_cnt_q == 3'd7);

    // State, bit position and comma count registers
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            active_q  <= active_d;
        end
    end

    // Next-state logic: hunt on every bit, then verify on the byte grid
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        active_d  = active_q;
        case (state_q)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (BC_TARGET == 4'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (at_boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (bc_cnt_d == BC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Grid broken: drop the count and hunt again
                        bc_cnt_d = 4'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // No loss-of-sync: stay here until reset
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign boundary = (state_q == ACTIVE) && at_boundary;
    assign active   = active_q;

endmodule

// File: rtl/serial_paralelo_bc.sv
// Receive-side serial-to-parallel stage with 0xBC comma alignment, running
// entirely on clk_32f. The output word is updated once per 8 bit clocks and
// held in between so slower downstream demux stages can sample it.
// Optional build macro: SERPAR_IDLE_ZERO_EN -- when defined, idle (comma)
// words are presented as 8'h00 instead of the raw comma.
module serial_paralelo_bc
    import serial_paralelo_bc_pkg::*;
#(
    parameter logic [7:0]  COMMA_CH = COMMA,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_bc_if.slave  bus
);

    // Only the seven most recent bits are ever needed: together with the
    // incoming bit they form the candidate byte.
    logic [6:0] shift_q;
    logic [7:0] cand;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       tick_q, tick_d;
    logic       boundary;
    logic       active;

    assign cand = {shift_q, bus.data_in};

    bc_detector #(
        .BC_COUNT (BC_COUNT),
        .COMMA_CH (COMMA_CH)
    ) u_bc_detector (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .cand     (cand),
        .boundary (boundary),
        .active   (active)
    );

    // Serial shift register, runs every cycle regardless of alignment
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            shift_q <= 7'd0;
        end else begin
            shift_q <= cand[6:0];
        end
    end

    // Output word update at each active word boundary, hold otherwise
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        tick_d     = 1'b0;
        if (boundary) begin
            tick_d  = 1'b1;
            valid_d = (cand != COMMA_CH);
`ifdef SERPAR_IDLE_ZERO_EN
            data_out_d = (cand != COMMA_CH) ? cand : 8'h00;
`else
            data_out_d = cand;
`endif
        end
    end

    // Output registers
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.word_tick = tick_q;
    assign bus.active    = active;

endmodule

// File: tb/tb_serial_paralelo_bc.sv
// Bench for serial_paralelo_bc: table of byte streams with expected output
// words, randomized streams checked cycle by cycle against a stream-level
// reference model, plus hand sequences for reset and word_tick spacing.
module tb_serial_paralelo_bc;

    localparam int         BC_COUNT = 4;
    localparam logic [7:0] BC       = 8'hBC;
`ifdef SERPAR_IDLE_ZERO_EN
    localparam logic [7:0] IDLE_W   = 8'h00;
`else
    localparam logic [7:0] IDLE_W   = 8'hBC;
`endif

    logic clk;
    logic reset;

    serial_paralelo_bc_if bus_if ();

    serial_paralelo_bc #(
        .COMMA_CH (BC),
        .BC_COUNT (BC_COUNT)
    ) dut (
        .clk_32f (clk),
        .reset   (reset),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       act;
        logic       tick;
        logic       v;
        logic [7:0] d;
    } obs_t;

    typedef struct {
        int               junk_n;
        logic [7:0]       junk;
        int               nbytes;
        logic [0:7][7:0]  bytes;
        int               nexp;
        logic [0:3][7:0]  exp_d;
        logic [0:3]       exp_v;
    } vec_t;

    vec_t       vecs [5];
    bit         stim_q [$];
    obs_t       exp_q [$];
    logic [7:0] cap_d [$];
    logic       cap_v [$];
    int         tick_t [$];

    int vectors;
    int miscompares;

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
    endtask

    task automatic push_zeros(input int n);
        for (int k = 0; k < n; k++) stim_q.push_back(1'b0);
    endtask

    // Byte whose last bit is stream bit i (bits before the stream are 0)
    function automatic logic [7:0] byte_at(input int i);
        logic [7:0] r;
        int idx;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            idx = i - 7 + b;
            r = {r[6:0], (idx >= 0) ? logic'(stim_q[idx]) : 1'b0};
        end
        return r;
    endfunction

    // Reference: find the first comma, then demand BC_COUNT commas spaced
    // exactly 8 bits apart; after that every 8th bit delivers a word.
    task automatic build_model();
        int   n;
        int   act_at;
        int   i;
        int   j;
        int   k;
        bit   broke;
        obs_t o;
        logic [7:0] w;
        n      = stim_q.size();
        act_at = -1;
        i      = 0;
        while (i < n && act_at < 0) begin
            if (byte_at(i) == BC) begin
                k = 1;
                j = i;
                broke = 1'b0;
                while (k < BC_COUNT) begin
                    j = j + 8;
                    if (j >= n) begin
                        broke = 1'b1;
                        break;
                    end
                    if (byte_at(j) == BC) k++;
                    else begin
                        broke = 1'b1;
                        break;
                    end
                end
                if (!broke) act_at = j;
                else if (j >= n) i = n;
                else i = j + 1;
            end else begin
                i++;
            end
        end
        exp_q.delete();
        o = '0;
        for (int t = 0; t < n; t++) begin
            o.tick = 1'b0;
            o.act  = (act_at >= 0) && (t >= act_at);
            if (act_at >= 0 && t > act_at && ((t - act_at) % 8) == 0) begin
                w      = byte_at(t);
                o.tick = 1'b1;
                o.v    = (w != BC);
                o.d    = (w != BC) ? w : IDLE_W;
            end
            exp_q.push_back(o);
        end
    endtask

    // Reset, then drive stim_q bit by bit, checking every cycle
    task automatic run_stream(input string name);
        obs_t got;
        build_model();
        cap_d.delete();
        cap_v.delete();
        tick_t.delete();
        reset = 1'b1;
        bus_if.data_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < stim_q.size(); t++) begin
            bus_if.data_in = stim_q[t];
            @(posedge clk);
            #1;
            got = {bus_if.active, bus_if.word_tick, bus_if.valid_out, bus_if.data_out};
            vectors++;
            if (got !== exp_q[t]) begin
                miscompares++;
                $display("FAIL %s cycle %0d act/tick/v/d got=%b/%b/%b/%02h want=%b/%b/%b/%02h",
                         name, t, got.act, got.tick, got.v, got.d,
                         exp_q[t].act, exp_q[t].tick, exp_q[t].v, exp_q[t].d);
            end
            if (bus_if.word_tick === 1'b1) begin
                cap_d.push_back(bus_if.data_out);
                cap_v.push_back(bus_if.valid_out);
                tick_t.push_back(t);
                $display("%s: word %02h valid %b at cycle %0d", name, bus_if.data_out, bus_if.valid_out, t);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus_if.data_in = 1'b0;

        vecs[0] = '{junk_n:3, junk:8'b101, nbytes:6,
                    bytes:{BC, BC, BC, BC, 8'h5A, 8'hFF, 8'h00, 8'h00},
                    nexp:2, exp_d:{8'h5A, 8'hFF, 8'h00, 8'h00}, exp_v:4'b1100};
        vecs[1] = '{junk_n:0, junk:8'h00, nbytes:7,
                    bytes:{BC, BC, BC, BC, 8'h12, BC, 8'h34, 8'h00},
                    nexp:3, exp_d:{8'h12, IDLE_W, 8'h34, 8'h00}, exp_v:4'b1010};
        vecs[2] = '{junk_n:0, junk:8'h00, nbytes:8,
                    bytes:{BC, BC, 8'h77, BC, BC, BC, BC, 8'h99},
                    nexp:1, exp_d:{8'h99, 8'h00, 8'h00, 8'h00}, exp_v:4'b1000};
        vecs[3] = '{junk_n:5, junk:8'b10110, nbytes:4,
                    bytes:{BC, BC, BC, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00},
                    nexp:0, exp_d:{8'h00, 8'h00, 8'h00, 8'h00}, exp_v:4'b0000};
        vecs[4] = '{junk_n:1, junk:8'b1, nbytes:8,
                    bytes:{BC, BC, BC, BC, 8'hA5, 8'hC3, BC, BC},
                    nexp:4, exp_d:{8'hA5, 8'hC3, IDLE_W, IDLE_W}, exp_v:4'b1100};

        // Reset state after 40 idle cycles
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if ({bus_if.active, bus_if.word_tick, bus_if.valid_out, bus_if.data_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL idle_reset got act=%b tick=%b v=%b d=%02h want all zero",
                     bus_if.active, bus_if.word_tick, bus_if.valid_out, bus_if.data_out);
        end

        // Table-driven streams
        for (int vi = 0; vi < 5; vi++) begin
            stim_q.delete();
            for (int b = vecs[vi].junk_n - 1; b >= 0; b--) stim_q.push_back(vecs[vi].junk[b]);
            for (int b = 0; b < vecs[vi].nbytes; b++) push_byte(vecs[vi].bytes[b]);
            push_zeros(16);
            run_stream($sformatf("table%0d", vi));
            for (int k = 0; k < vecs[vi].nexp; k++) begin
                vectors++;
                if (k >= cap_d.size()) begin
                    miscompares++;
                    $display("FAIL table%0d word%0d got=none want=%02h/%b", vi, k,
                             vecs[vi].exp_d[k], vecs[vi].exp_v[k]);
                end else if (cap_d[k] !== vecs[vi].exp_d[k] || cap_v[k] !== vecs[vi].exp_v[k]) begin
                    miscompares++;
                    $display("FAIL table%0d word%0d got=%02h/%b want=%02h/%b", vi, k,
                             cap_d[k], cap_v[k], vecs[vi].exp_d[k], vecs[vi].exp_v[k]);
                end
            end
            if (vecs[vi].nexp == 0) begin
                vectors++;
                if (cap_d.size() != 0 || bus_if.active !== 1'b0) begin
                    miscompares++;
                    $display("FAIL table%0d no_align got ticks=%0d act=%b want ticks=0 act=0",
                             vi, cap_d.size(), bus_if.active);
                end
            end
        end

        // Asynchronous reset three bits into a payload byte
        stim_q.delete();
        for (int k = 0; k < 4; k++) push_byte(BC);
        push_byte(8'h5A);
        stim_q.push_back(1'b1);
        stim_q.push_back(1'b1);
        stim_q.push_back(1'b0);
        run_stream("midreset_pre");
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus_if.active, bus_if.word_tick, bus_if.valid_out, bus_if.data_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset got act=%b tick=%b v=%b d=%02h want all zero before clock",
                     bus_if.active, bus_if.word_tick, bus_if.valid_out, bus_if.data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        stim_q.delete();
        for (int k = 0; k < 4; k++) push_byte(BC);
        push_byte(8'h01);
        push_zeros(8);
        run_stream("midreset_post");
        vectors++;
        if (cap_d.size() == 0 || cap_d[0] !== 8'h01 || cap_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL realign_first_word got=%02h/%b want=01/1",
                     (cap_d.size() != 0) ? cap_d[0] : 8'hxx, (cap_v.size() != 0) ? cap_v[0] : 1'bx);
        end

        // word_tick spacing across 10 payload words
        stim_q.delete();
        for (int k = 0; k < 4; k++) push_byte(BC);
        for (int k = 0; k < 10; k++) push_byte(8'($urandom_range(0, 8'hBB)));
        run_stream("spacing");
        vectors++;
        if (tick_t.size() != 10) begin
            miscompares++;
            $display("FAIL tick_count got=%0d want=10", tick_t.size());
        end
        for (int k = 1; k < tick_t.size(); k++) begin
            vectors++;
            if (tick_t[k] - tick_t[k-1] != 8) begin
                miscompares++;
                $display("FAIL tick_spacing%0d got=%0d want=8", k, tick_t[k] - tick_t[k-1]);
            end
        end

        // Randomized streams against the reference model
        for (int r = 0; r < 20; r++) begin
            int nj;
            int nbc;
            int np;
            stim_q.delete();
            nj  = $urandom_range(0, 7);
            nbc = $urandom_range(2, 5);
            np  = $urandom_range(1, 6);
            for (int k = 0; k < nj; k++) stim_q.push_back(bit'($urandom_range(0, 1)));
            for (int k = 0; k < nbc; k++) push_byte(BC);
            for (int k = 0; k < np; k++) begin
                if ($urandom_range(0, 3) == 0) push_byte(BC);
                else push_byte(8'($urandom));
            end
            push_zeros(8);
            run_stream($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
